// File: rtl/bus_matrix_pkg.sv
// Shared definitions for bus_matrix: controller state encoding and slave-index field.
package bus_matrix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Slave index is taken from the top SIDX_W address bits.
  localparam int SIDX_W = 4;

endpackage

// File: rtl/bus_matrix_rr_arbiter.sv
// Combinational winner select: first requester at/after ptr (mode=1) or lowest index (mode=0).
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          mode,
  output logic [N-1:0]  gnt
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req[j] && (j == (((mode ? int'(ptr) : 0) + i) % N))) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_matrix.sv
// Shared-bus matrix: arbitrates masters in IDLE, runs one slave access (with timeout), returns a one-cycle response.
module bus_matrix
  import bus_matrix_pkg::*;
#(
  parameter int MST_NUM = 4,
  parameter int SLV_NUM = 8,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RR_EN   = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [MST_NUM-1:0]    m_req_i,
  input  logic [MST_NUM-1:0]    m_we_i,
  input  logic [MST_NUM*AW-1:0] m_addr_i,
  input  logic [MST_NUM*DW-1:0] m_wdata_i,
  output logic [MST_NUM-1:0]    m_gnt_o,
  output logic [MST_NUM-1:0]    m_rvalid_o,
  output logic [DW-1:0]         m_rdata_o,
  output logic                  m_err_o,
  output logic [SLV_NUM-1:0]    s_sel_o,
  output logic                  s_we_o,
  output logic [AW-1:0]         s_addr_o,
  output logic [DW-1:0]         s_wdata_o,
  input  logic [SLV_NUM*DW-1:0] s_rdata_i,
  input  logic [SLV_NUM-1:0]    s_ready_i
);

  localparam int PW = (MST_NUM > 1) ? $clog2(MST_NUM) : 1;
  localparam logic [SIDX_W:0] SLV_LIM = (SIDX_W+1)'(SLV_NUM);

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr, win;
  logic              first_r, we_r, mapped_r, err_r;
  logic [AW-1:0]     addr_r;
  logic [DW-1:0]     wdata_r, rdata_r;
  logic [SIDX_W-1:0] sidx_r;
  logic [15:0]       wait_cnt;

  logic [MST_NUM-1:0] arb_gnt;
  logic [PW-1:0]      arb_idx;
  logic               arb_we;
  logic [AW-1:0]      arb_addr;
  logic [DW-1:0]      arb_wdata;
  logic [SIDX_W-1:0]  req_sidx;
  logic               req_mapped;
  logic               sel_ready;
  logic [DW-1:0]      sel_rdata;
  logic               timeout_hit;

  rr_arbiter #(.N(MST_NUM), .PW(PW)) u_arb (
    .req  (m_req_i),
    .ptr  (ptr),
    .mode (RR_EN != 0),
    .gnt  (arb_gnt)
  );

  always_comb begin
    arb_idx   = '0;
    arb_we    = 1'b0;
    arb_addr  = '0;
    arb_wdata = '0;
    for (int j = 0; j < MST_NUM; j++) begin
      if (arb_gnt[j]) begin
        arb_idx   = PW'(j);
        arb_we    = m_we_i[j];
        arb_addr  = m_addr_i[j*AW +: AW];
        arb_wdata = m_wdata_i[j*DW +: DW];
      end
    end
  end

  assign req_sidx    = arb_addr[AW-1 -: SIDX_W];
  assign req_mapped  = ({1'b0, req_sidx} < SLV_LIM);
  assign timeout_hit = (wait_cnt == 16'(TIMEOUT - 1));

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int s = 0; s < SLV_NUM; s++) begin
      if (sidx_r == SIDX_W'(s)) begin
        sel_ready = s_ready_i[s];
        sel_rdata = s_rdata_i[s*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (|m_req_i) state_nxt = ST_ACCESS;
      ST_ACCESS: if (!mapped_r || sel_ready || timeout_hit) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      win      <= '0;
      first_r  <= 1'b0;
      we_r     <= 1'b0;
      addr_r   <= '0;
      wdata_r  <= '0;
      sidx_r   <= '0;
      mapped_r <= 1'b0;
      wait_cnt <= '0;
      rdata_r  <= '0;
      err_r    <= 1'b0;
    end else begin
      first_r <= 1'b0;
      case (state)
        ST_IDLE: if (|m_req_i) begin
          win      <= arb_idx;
          we_r     <= arb_we;
          addr_r   <= arb_addr;
          wdata_r  <= arb_wdata;
          sidx_r   <= req_sidx;
          mapped_r <= req_mapped;
          first_r  <= 1'b1;
          wait_cnt <= '0;
        end
        ST_ACCESS: begin
          // Ready beats timeout when both land in the same cycle.
          if (!mapped_r) begin
            err_r   <= 1'b1;
            rdata_r <= '0;
          end else if (sel_ready) begin
            err_r   <= 1'b0;
            rdata_r <= sel_rdata;
          end else if (timeout_hit) begin
            err_r   <= 1'b1;
            rdata_r <= '0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_RESP: if (RR_EN != 0) ptr <= (win == PW'(MST_NUM - 1)) ? '0 : win + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    m_err_o    = 1'b0;
    s_sel_o    = '0;
    s_we_o     = 1'b0;
    s_addr_o   = '0;
    s_wdata_o  = '0;
    for (int j = 0; j < MST_NUM; j++) begin
      if (win == PW'(j)) begin
        m_gnt_o[j]    = (state == ST_ACCESS) && first_r;
        m_rvalid_o[j] = (state == ST_RESP);
      end
    end
    for (int s = 0; s < SLV_NUM; s++) begin
      if (sidx_r == SIDX_W'(s)) s_sel_o[s] = (state == ST_ACCESS) && mapped_r;
    end
    if (state == ST_ACCESS && mapped_r) begin
      s_we_o    = we_r;
      s_addr_o  = addr_r;
      s_wdata_o = wdata_r;
    end
    if (state == ST_RESP) begin
      m_rdata_o = rdata_r;
      m_err_o   = err_r;
    end
  end

endmodule

// File: tb/tb_bus_matrix.sv
// Drives a round-robin and a fixed-priority bus_matrix with random traffic and checks both against a transaction model.
module tb_bus_matrix;

  localparam int M  = 4;
  localparam int S  = 8;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [M-1:0]    req      [2];
  logic [M-1:0]    we_in    [2];
  logic [M*AW-1:0] addr_in  [2];
  logic [M*DW-1:0] wdata_in [2];
  logic [S*DW-1:0] srd      [2];
  logic [S-1:0]    rdy      [2];
  logic [M-1:0]    gnt      [2];
  logic [M-1:0]    rv       [2];
  logic [DW-1:0]   rdata    [2];
  logic            err      [2];
  logic [S-1:0]    sel      [2];
  logic            swe      [2];
  logic [AW-1:0]   saddr    [2];
  logic [DW-1:0]   swdata   [2];

  bus_matrix #(.MST_NUM(M), .SLV_NUM(S), .AW(AW), .DW(DW), .RR_EN(1), .TIMEOUT(TO)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .m_req_i(req[0]), .m_we_i(we_in[0]), .m_addr_i(addr_in[0]), .m_wdata_i(wdata_in[0]),
    .m_gnt_o(gnt[0]), .m_rvalid_o(rv[0]), .m_rdata_o(rdata[0]), .m_err_o(err[0]),
    .s_sel_o(sel[0]), .s_we_o(swe[0]), .s_addr_o(saddr[0]), .s_wdata_o(swdata[0]),
    .s_rdata_i(srd[0]), .s_ready_i(rdy[0])
  );

  bus_matrix #(.MST_NUM(M), .SLV_NUM(S), .AW(AW), .DW(DW), .RR_EN(0), .TIMEOUT(TO)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .m_req_i(req[1]), .m_we_i(we_in[1]), .m_addr_i(addr_in[1]), .m_wdata_i(wdata_in[1]),
    .m_gnt_o(gnt[1]), .m_rvalid_o(rv[1]), .m_rdata_o(rdata[1]), .m_err_o(err[1]),
    .s_sel_o(sel[1]), .s_we_o(swe[1]), .s_addr_o(saddr[1]), .s_wdata_o(swdata[1]),
    .s_rdata_i(srd[1]), .s_ready_i(rdy[1])
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction model: age 0 = idle, 1..len = slave access cycles, len+1 = response cycle.
  int            age [2], len [2], win [2], ptr [2], tdly [2], sidx [2], granted [2];
  bit            mapped [2], twe [2], exp_err [2];
  logic [AW-1:0] taddr [2];
  logic [DW-1:0] twdata [2], exp_rd [2];

  logic [M-1:0] allow;
  int           p_req, force_dly;
  bit           cont, force_s1;
  int           fp_m2_gnts, rr_m2_gnts;

  task automatic new_payload(input int i, input int k);
    int idx;
    idx = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
    we_in[i][k] = 1'($urandom);
    addr_in[i][k*AW +: AW]  = {4'(idx), 28'($urandom)};
    wdata_in[i][k*DW +: DW] = $urandom;
  endtask

  task automatic check_outputs(input int i);
    logic [M-1:0]  e_gnt, e_rv;
    logic [S-1:0]  e_sel;
    logic          e_we, e_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_rd;
    string nm;
    nm = (i == 0) ? "rr" : "fp";
    e_gnt = '0; e_rv = '0; e_sel = '0; e_we = 1'b0; e_err = 1'b0;
    e_addr = '0; e_wd = '0; e_rd = '0;
    if (age[i] >= 1 && age[i] <= len[i]) begin
      if (age[i] == 1) e_gnt[win[i]] = 1'b1;
      if (mapped[i]) begin
        e_sel[sidx[i]] = 1'b1;
        e_we   = twe[i];
        e_addr = taddr[i];
        e_wd   = twdata[i];
      end
    end else if (age[i] == len[i] + 1) begin
      e_rv[win[i]] = 1'b1;
      e_rd  = exp_rd[i];
      e_err = exp_err[i];
    end
    chk({nm, ".gnt"},    64'(gnt[i]),    64'(e_gnt));
    chk({nm, ".rvalid"}, 64'(rv[i]),     64'(e_rv));
    chk({nm, ".rdata"},  64'(rdata[i]),  64'(e_rd));
    chk({nm, ".err"},    64'(err[i]),    64'(e_err));
    chk({nm, ".sel"},    64'(sel[i]),    64'(e_sel));
    chk({nm, ".s_we"},   64'(swe[i]),    64'(e_we));
    chk({nm, ".s_addr"}, 64'(saddr[i]),  64'(e_addr));
    chk({nm, ".s_wdat"}, 64'(swdata[i]), 64'(e_wd));
  endtask

  task automatic drive(input int i);
    for (int k = 0; k < M; k++) begin
      if (granted[i] == k) begin
        if (cont) new_payload(i, k);
        else      req[i][k] = 1'b0;
      end else if (!req[i][k] && allow[k] && $urandom_range(0, 99) < p_req) begin
        req[i][k] = 1'b1;
        new_payload(i, k);
      end
    end
    for (int s = 0; s < S; s++) srd[i][s*DW +: DW] = $urandom;
    if (force_s1) srd[i][1*DW +: DW] = 32'hDEAD_BEEF;
    rdy[i] = 8'($urandom);
    if (age[i] >= 1 && age[i] <= len[i] && mapped[i]) rdy[i][sidx[i]] = (age[i] >= tdly[i] + 1);
  endtask

  task automatic step(input int i);
    int base, w;
    granted[i] = -1;
    if (age[i] == 0) begin
      if (req[i] != '0) begin
        base = (i == 0) ? ptr[i] : 0;
        w = -1;
        for (int off = 0; off < M; off++)
          if (w < 0 && req[i][(base + off) % M]) w = (base + off) % M;
        win[i]    = w;
        granted[i] = w;
        twe[i]    = we_in[i][w];
        taddr[i]  = addr_in[i][w*AW +: AW];
        twdata[i] = wdata_in[i][w*DW +: DW];
        sidx[i]   = int'(taddr[i][AW-1 -: 4]);
        mapped[i] = (sidx[i] < S);
        tdly[i]   = (force_dly >= 0) ? force_dly : $urandom_range(0, 5);
        len[i]    = !mapped[i] ? 1 : ((tdly[i] + 1 < TO) ? tdly[i] + 1 : TO);
        age[i]    = 1;
      end
    end else if (age[i] <= len[i]) begin
      if (age[i] == len[i]) begin
        if (mapped[i] && age[i] >= tdly[i] + 1) begin
          exp_err[i] = 1'b0;
          exp_rd[i]  = srd[i][sidx[i]*DW +: DW];
        end else begin
          exp_err[i] = 1'b1;
          exp_rd[i]  = '0;
        end
      end
      age[i]++;
    end else begin
      if (i == 0) ptr[i] = (win[i] + 1) % M;
      age[i] = 0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      age[i] = 0; len[i] = 0; win[i] = 0; ptr[i] = 0; granted[i] = -1;
      req[i] = '0; we_in[i] = '0; addr_in[i] = '0; wdata_in[i] = '0;
      srd[i] = '0; rdy[i] = '0;
    end
  endtask

  // All work happens at a falling edge; returns at the next falling edge.
  task automatic cycle();
    for (int i = 0; i < 2; i++) begin
      check_outputs(i);
      drive(i);
      step(i);
    end
    if (gnt[1][2]) fp_m2_gnts++;
    if (gnt[0][2]) rr_m2_gnts++;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    p_req = 0; cont = 1'b0; force_dly = -1; force_s1 = 1'b0;
    n = 0;
    while (!(age[0] == 0 && age[1] == 0 && req[0] == '0 && req[1] == '0) && n < 60) begin
      cycle();
      n++;
    end
    chk("drain_done", 64'(n < 60), 64'd1);
  endtask

  task automatic preload(input logic [M-1:0] mask);
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < M; k++)
        if (mask[k]) begin
          req[i][k] = 1'b1;
          new_payload(i, k);
        end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, ".gnt"},   64'(gnt[i]), 64'd0);
      chk({tag, ".rv"},    64'(rv[i]), 64'd0);
      chk({tag, ".rdata"}, 64'(rdata[i]), 64'd0);
      chk({tag, ".err"},   64'(err[i]), 64'd0);
      chk({tag, ".sel"},   64'(sel[i]), 64'd0);
      chk({tag, ".bus"},   64'(swe[i]) | 64'(saddr[i]) | 64'(swdata[i]), 64'd0);
    end
  endtask

  initial begin
    int n;
    model_reset();
    allow = '0; p_req = 0; cont = 1'b0; force_dly = -1; force_s1 = 1'b0;
    fp_m2_gnts = 0; rr_m2_gnts = 0;

    // Reset state
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Single read: M1 reads 0x1000_0010, S1 answers immediately with 0xDEADBEEF
    for (int i = 0; i < 2; i++) begin
      req[i][1] = 1'b1;
      we_in[i][1] = 1'b0;
      addr_in[i][1*AW +: AW] = 32'h1000_0010;
    end
    force_dly = 0; force_s1 = 1'b1;
    for (int c = 0; c < 6; c++) cycle();
    drain();

    // Four masters requesting continuously
    allow = 4'hF; cont = 1'b1; p_req = 0;
    preload(4'hF);
    cont = 1'b1;
    for (int c = 0; c < 40; c++) cycle();
    drain();

    // M0 and M2 requesting continuously: fixed priority must starve M2
    fp_m2_gnts = 0; rr_m2_gnts = 0;
    allow = 4'b0101;
    preload(4'b0101);
    cont = 1'b1;
    for (int c = 0; c < 45; c++) cycle();
    chk("fp.m2_starved", 64'(fp_m2_gnts), 64'd0);
    chk("rr.m2_served",  64'(rr_m2_gnts > 0), 64'd1);
    drain();

    // Random traffic: mixed reads/writes, unmapped slaves, stalls and timeouts
    allow = 4'hF; cont = 1'b0; p_req = 30;
    for (int c = 0; c < 1500; c++) cycle();

    // Reset abort in the middle of a stalled access
    allow = 4'hF; p_req = 60; force_dly = 5;
    n = 0;
    while (!(age[0] >= 1 && age[0] < len[0]) && n < 60) begin
      cycle();
      n++;
    end
    chk("abort_setup", 64'(n < 60), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("abort");
    @(negedge clk);
    check_all_zero("abort_hold");
    model_reset();
    rst_n = 1'b1;
    force_dly = -1; p_req = 0; cont = 1'b1;
    preload(4'hF);
    cycle();
    chk("rr.post_reset_gnt", 64'(gnt[0]), 64'b0001);
    for (int c = 0; c < 20; c++) cycle();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
